// File: rtl/aes128_iter_core.sv
// rtl/aes128_iter_core.sv - iterative AES-128 encryption core with configurable S-box lanes
// Substitutes LANES state bytes per cycle; ShiftRows/MixColumns/AddRoundKey and key expansion run on the last lane.
module aes128_iter_core #(
  parameter int LANES = 16
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] Din,
  input  logic [127:0] Kin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] Dout,
  output logic         busy
);

  localparam int CPR = 16 / LANES;
  localparam int SW  = 8 * LANES;

  if (LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("aes128_iter_core: LANES must be 4, 8 or 16");
  end

  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       fsm;
  logic [127:0] st;
  logic [127:0] rk;
  logic [3:0]   round;
  logic [1:0]   lane;
  logic [7:0]   rcon;

  // Entry k of the table sits at bits [2047-8k -: 8], i.e. {~k, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TAB[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(15-(4*c+r)) +: 8] = s[8*(15-(4*((c+r)%4)+r)) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  logic [6:0]    base;
  logic [SW-1:0] slice_in, slice_out;
  logic [127:0]  sub_full, sr, mc, nk, rnd_out;
  logic [31:0]   sub_word;
  logic          last_lane, accept;

  assign last_lane = (lane == 2'(CPR - 1));
  assign in_ready  = (fsm == IDLE) || ((fsm == DONE) && out_ready);
  assign accept    = in_valid && in_ready;

  always_comb begin
    base      = 7'(SW * (CPR - 1 - int'(lane)));
    slice_in  = st[base +: SW];
    slice_out = '0;
    for (int i = 0; i < LANES; i++) begin
      slice_out[8*i +: 8] = sbox(slice_in[8*i +: 8]);
    end
    sub_full             = st;
    sub_full[base +: SW] = slice_out;
  end

  // Key schedule has its own four S-boxes so it stays one step per round regardless of LANES.
  always_comb begin
    sub_word = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])};
    nk[127:96] = rk[127:96] ^ sub_word ^ {rcon, 24'h0};
    nk[95:64]  = nk[127:96] ^ rk[95:64];
    nk[63:32]  = nk[95:64] ^ rk[63:32];
    nk[31:0]   = nk[63:32] ^ rk[31:0];
    sr = shift_rows(sub_full);
    mc = (round == 4'd10) ? sr :
         {mix_col(sr[127:96]), mix_col(sr[95:64]), mix_col(sr[63:32]), mix_col(sr[31:0])};
    rnd_out = mc ^ nk;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      fsm       <= IDLE;
      st        <= '0;
      rk        <= '0;
      round     <= '0;
      lane      <= '0;
      rcon      <= '0;
      Dout      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (accept) begin
      st        <= Din ^ Kin;
      rk        <= Kin;
      rcon      <= 8'h01;
      round     <= 4'd1;
      lane      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b1;
      fsm       <= RUN;
    end else begin
      case (fsm)
        RUN: begin
          if (!last_lane) begin
            st   <= sub_full;
            lane <= lane + 2'd1;
          end else begin
            st    <= rnd_out;
            rk    <= nk;
            rcon  <= xtime(rcon);
            lane  <= '0;
            round <= round + 4'd1;
            if (round == 4'd10) begin
              Dout      <= rnd_out;
              out_valid <= 1'b1;
              busy      <= 1'b0;
              fsm       <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_iter_core.sv
// tb/tb_aes128_iter_core.sv - self-checking bench for aes128_iter_core
// Reference model builds its S-box from GF(2^8) inversion plus the affine map.
module tb_aes128_iter_core;

  logic         CLK = 1'b0;
  logic         RSTn = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] Din = '0;
  logic [127:0] Kin = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] Dout;
  logic         in_ready8, out_valid8, busy8;
  logic [127:0] Dout8;
  logic         in_ready16, out_valid16, busy16;
  logic [127:0] Dout16;

  int total = 0;
  int bad = 0;
  logic [7:0] sb [256];

  localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] BK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BP  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] BC  = 128'h3925841d02dc09fbdc118597196a0b32;

  always #5 CLK = ~CLK;

  aes128_iter_core #(.LANES(4)) dut (
    .CLK(CLK), .RSTn(RSTn), .in_valid(in_valid), .in_ready(in_ready), .Din(Din), .Kin(Kin),
    .out_valid(out_valid), .out_ready(out_ready), .Dout(Dout), .busy(busy));

  aes128_iter_core #(.LANES(8)) d8 (
    .CLK(CLK), .RSTn(RSTn), .in_valid(in_valid), .in_ready(in_ready8), .Din(Din), .Kin(Kin),
    .out_valid(out_valid8), .out_ready(out_ready), .Dout(Dout8), .busy(busy8));

  aes128_iter_core #(.LANES(16)) d16 (
    .CLK(CLK), .RSTn(RSTn), .in_valid(in_valid), .in_ready(in_ready16), .Din(Din), .Kin(Kin),
    .out_valid(out_valid16), .out_ready(out_ready), .Dout(Dout16), .busy(busy16));

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x] = s;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] k [16];
    logic [7:0] rc = 8'h01;
    logic [7:0] w0, w1, w2, w3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++) begin
        if (rnd < 10) begin
          s[4*c]   = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
          s[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
        end
      end
      w0 = sb[k[13]]; w1 = sb[k[14]]; w2 = sb[k[15]]; w3 = sb[k[12]];
      k[0] ^= w0 ^ rc; k[1] ^= w1; k[2] ^= w2; k[3] ^= w3;
      for (int i = 4; i < 16; i++) k[i] ^= k[i-4];
      rc = gmul(rc, 8'h02);
      for (int i = 0; i < 16; i++) s[i] ^= k[i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_out(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
  endtask

  task automatic run_block(input logic [127:0] k, input logic [127:0] p,
                           output logic [127:0] ct, output int lat);
    Din = p; Kin = k; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    wait_out(lat);
    ct = Dout;
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (Dout !== 128'h0) begin bad++; $display("FAIL reset_dout got=%h want=0", Dout); end
    @(negedge CLK); RSTn = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_latency();
    int l4 = -1, l8 = -1, l16 = -1;
    Din = C1P; Kin = C1K; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    total++; if (busy !== 1'b1 || in_ready !== 1'b0)
      begin bad++; $display("FAIL run_flags busy=%b in_ready=%b want busy=1 in_ready=0", busy, in_ready); end
    for (int c = 1; c <= 60; c++) begin
      @(posedge CLK); #1;
      if (out_valid === 1'b1 && l4 < 0) l4 = c;
      if (out_valid8 === 1'b1 && l8 < 0) l8 = c;
      if (out_valid16 === 1'b1 && l16 < 0) l16 = c;
    end
    total++; if (l4 != 40) begin bad++; $display("FAIL latency_l4 got=%0d want=40", l4); end
    total++; if (l8 != 20) begin bad++; $display("FAIL latency_l8 got=%0d want=20", l8); end
    total++; if (l16 != 10) begin bad++; $display("FAIL latency_l16 got=%0d want=10", l16); end
    total++; if (Dout !== C1C) begin bad++; $display("FAIL c1_l4 got=%h want=%h", Dout, C1C); end
    total++; if (Dout8 !== C1C) begin bad++; $display("FAIL c1_l8 got=%h want=%h", Dout8, C1C); end
    total++; if (Dout16 !== C1C) begin bad++; $display("FAIL c1_l16 got=%h want=%h", Dout16, C1C); end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL consume out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    total++; if (Dout !== C1C) begin bad++; $display("FAIL dout_kept got=%h want=%h", Dout, C1C); end
  endtask

  task automatic test_fips_b();
    logic [127:0] ct;
    int lat;
    run_block(BK, BP, ct, lat);
    total++; if (ct !== BC) begin bad++; $display("FAIL fips_b got=%h want=%h", ct, BC); end
    total++; if (lat != 40) begin bad++; $display("FAIL fips_b_lat got=%0d want=40", lat); end
  endtask

  task automatic test_random();
    logic [127:0] k, p, ct, exp;
    int lat;
    for (int i = 0; i < 6; i++) begin
      k = rand128(); p = rand128();
      exp = aes_ref(k, p);
      run_block(k, p, ct, lat);
      total++; if (ct !== exp || lat != 40)
        begin bad++; $display("FAIL random%0d got=%h lat=%0d want=%h lat=40", i, ct, lat, exp); end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] k, p, k2, p2, held, exp2;
    int n;
    k = rand128(); p = rand128(); k2 = rand128(); p2 = rand128();
    exp2 = aes_ref(k2, p2);
    Din = p; Kin = k; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    wait_out(n);
    held = Dout;
    total++; if (held !== aes_ref(k, p) || n != 40)
      begin bad++; $display("FAIL bp_first got=%h lat=%0d want=%h lat=40", held, n, aes_ref(k, p)); end
    Din = p2; Kin = k2; in_valid = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(posedge CLK); #1;
      total++; if (Dout !== held || in_ready !== 1'b0 || out_valid !== 1'b1)
        begin bad++; $display("FAIL bp_hold%0d dout=%h in_ready=%b out_valid=%b want dout=%h 0 1", c, Dout, in_ready, out_valid, held); end
    end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    total++; if (busy !== 1'b1 || out_valid !== 1'b0)
      begin bad++; $display("FAIL bp_accept busy=%b out_valid=%b want 1/0", busy, out_valid); end
    wait_out(n);
    total++; if (Dout !== exp2 || n != 40)
      begin bad++; $display("FAIL bp_second got=%h lat=%0d want=%h lat=40", Dout, n, exp2); end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    Din = C1P; Kin = C1K; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge CLK); #1;
    Din = BP; Kin = BK;
    wait_out(n);
    total++; if (Dout !== C1C || n != 40)
      begin bad++; $display("FAIL b2b_first got=%h lat=%0d want=%h lat=40", Dout, n, C1C); end
    @(posedge CLK); #1;
    total++; if (out_valid !== 1'b0 || busy !== 1'b1)
      begin bad++; $display("FAIL b2b_noidle out_valid=%b busy=%b want 0/1", out_valid, busy); end
    in_valid = 1'b0;
    wait_out(n);
    total++; if (Dout !== BC || n != 40)
      begin bad++; $display("FAIL b2b_second got=%h lat=%0d want=%h lat=40", Dout, n, BC); end
    @(posedge CLK); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midrun();
    logic [127:0] ct;
    int lat;
    logic seen = 1'b0;
    Din = rand128(); Kin = rand128(); in_valid = 1'b1; out_ready = 1'b0;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge CLK);
    #1 RSTn = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || Dout !== 128'h0)
      begin bad++; $display("FAIL midrun_reset out_valid=%b in_ready=%b busy=%b dout=%h want 0 1 0 0", out_valid, in_ready, busy, Dout); end
    @(negedge CLK); RSTn = 1'b1;
    for (int c = 0; c < 45; c++) begin
      @(posedge CLK); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrun_discard got=%b want=0", seen); end
    run_block(C1K, C1P, ct, lat);
    total++; if (ct !== C1C || lat != 40)
      begin bad++; $display("FAIL midrun_after got=%h lat=%0d want=%h lat=40", ct, lat, C1C); end
  endtask

  task automatic test_ignore_busy();
    logic [127:0] k, p, exp;
    int n = 0;
    k = rand128(); p = rand128();
    exp = aes_ref(k, p);
    Din = p; Kin = k; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge CLK); #1;
    while (out_valid !== 1'b1 && n < 200) begin
      Din = rand128(); Kin = rand128();
      @(posedge CLK); #1;
      n++;
    end
    in_valid = 1'b0;
    total++; if (Dout !== exp || n != 40)
      begin bad++; $display("FAIL ignore_busy got=%h lat=%0d want=%h lat=40", Dout, n, exp); end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_latency();
    test_fips_b();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_midrun();
    test_ignore_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
